// File: rtl/alu_pipe_if.sv
// Handshake and data bundle between the operand sequencer, alu_pipe and the result consumer.
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [2:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic             zero;
    logic             neg;

    // Sequencer/consumer side
    modport master (
        output in_valid, opA, opB, sel, out_ready,
        input  in_ready, out_valid, res, ovf, zero, neg
    );

    // ALU side
    modport slave (
        input  in_valid, opA, opB, sel, out_ready,
        output in_ready, out_valid, res, ovf, zero, neg
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined multi-format ALU: 2C / 1C / sign-magnitude add/sub plus AND/OR,
// with valid/ready on both sides and overflow/zero/negative flags.
module alu_pipe #(
    parameter int unsigned WIDTH    = 8,
    parameter bit          SATURATE = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    alu_pipe_if.slave bus
);

    typedef enum logic [1:0] {
        FMT_2C    = 2'b00,
        FMT_1C    = 2'b01,
        FMT_SM    = 2'b10,
        FMT_LOGIC = 2'b11
    } fmt_e;

    localparam logic [WIDTH:0]   POS_LIM   = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH:0]   NEG_LIM   = {2'b01, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SIGN_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             v1;
    logic             v2;
    logic             adv2;
    logic             in_ready_c;

    fmt_e             fmt_in;
    fmt_e             fmt1;
    logic             sa_c, sb_c, sa1, sb1;
    logic [WIDTH-1:0] ma_c, mb_c, ma1, mb1;
    logic [WIDTH-1:0] lres_c, lres1;

    logic [WIDTH:0]   tmag;
    logic             tsign;
    logic [WIDTH-2:0] mlow;
    logic             ovf_c;
    logic [WIDTH-1:0] res_c;

    logic [WIDTH-1:0] res_q;
    logic             ovf_q;
    logic             zero_q;
    logic             neg_q;

    // Unsigned magnitude of an operand; both negative-zero encodings collapse to 0.
    function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v, input fmt_e f);
        logic [WIDTH-1:0] m;
        case (f)
            FMT_2C:  m = v[WIDTH-1] ? (~v + ONE) : v;
            FMT_1C:  m = v[WIDTH-1] ? ~v : v;
            FMT_SM:  m = {1'b0, v[WIDTH-2:0]};
            default: m = '0;
        endcase
        return m;
    endfunction

    // Stage 2 advances when empty or drained; stage 1 loads when empty or able to advance,
    // which is the same condition as ~v1 | ~v2 | out_ready.
    always_comb begin
        adv2       = ~v2 | bus.out_ready;
        in_ready_c = ~v1 | adv2;
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = v2;
    assign bus.res       = res_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;

    // Decode: split operands into sign/magnitude; subtraction flips B's sign.
    always_comb begin
        fmt_in = fmt_e'(bus.sel[2:1]);
        ma_c   = mag_of(bus.opA, fmt_in);
        mb_c   = mag_of(bus.opB, fmt_in);
        sa_c   = bus.opA[WIDTH-1] & (ma_c != '0);
        sb_c   = (bus.opB[WIDTH-1] & (mb_c != '0)) ^ bus.sel[0];
        lres_c = bus.sel[0] ? (bus.opA | bus.opB) : (bus.opA & bus.opB);
    end

    // Stage 1 register: decoded operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
        end else if (in_ready_c) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                fmt1  <= fmt_in;
                sa1   <= sa_c;
                sb1   <= sb_c;
                ma1   <= ma_c;
                mb1   <= mb_c;
                lres1 <= lres_c;
            end
        end
    end

    // Compute: signed-magnitude add, range check, then re-encode in the selected format.
    always_comb begin
        tmag  = '0;
        tsign = 1'b0;
        ovf_c = 1'b0;
        res_c = '0;
        if (sa1 == sb1) begin
            tmag  = {1'b0, ma1} + {1'b0, mb1};
            tsign = sa1;
        end else if (ma1 >= mb1) begin
            tmag  = {1'b0, ma1} - {1'b0, mb1};
            tsign = sa1;
        end else begin
            tmag  = {1'b0, mb1} - {1'b0, ma1};
            tsign = sb1;
        end
        if (tmag == '0) begin
            tsign = 1'b0;
        end
        mlow = tmag[WIDTH-2:0];
        case (fmt1)
            FMT_2C: begin
                ovf_c = tsign ? (tmag > NEG_LIM) : (tmag > POS_LIM);
                if (ovf_c && SATURATE) begin
                    res_c = tsign ? SIGN_ONLY : MAX_POS;
                end else begin
                    res_c = tsign ? (~tmag[WIDTH-1:0] + ONE) : tmag[WIDTH-1:0];
                end
            end
            FMT_1C, FMT_SM: begin
                ovf_c = tmag > POS_LIM;
                if (ovf_c && SATURATE) begin
                    res_c = tsign ? ((fmt1 == FMT_1C) ? SIGN_ONLY : '1) : MAX_POS;
                end else if (mlow == '0) begin
                    res_c = '0;
                end else if (!tsign) begin
                    res_c = {1'b0, mlow};
                end else if (fmt1 == FMT_1C) begin
                    res_c = ~{1'b0, mlow};
                end else begin
                    res_c = {1'b1, mlow};
                end
            end
            default: res_c = lres1;
        endcase
    end

    // Stage 2 register: result and flags, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2     <= 1'b0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                res_q  <= res_c;
                ovf_q  <= ovf_c;
                zero_q <= (res_c == '0);
                neg_q  <= res_c[WIDTH-1];
            end
        end
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the team's combinational 8-bit multi-format ALU.
- Performs add/sub in two's-complement, one's-complement or sign-magnitude, plus bitwise AND/OR, on WIDTH-bit operands.
- Two register stages with valid/ready handshakes on both sides, and overflow/zero/negative flags.
- Sits between an operand sequencer and a result consumer that may apply backpressure.

Parameters:
- WIDTH, 8, operand/result width; legal range 2 or more.
- SATURATE, 0, overflow policy: 1 clamps to the representable limit; 0 wraps (rules below).

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts beat this cycle
- opA  in  WIDTH  operand A
- opB  in  WIDTH  operand B
- sel  in  3  000 2C add, 001 2C sub, 010 1C add, 011 1C sub, 100 SM add, 101 SM sub, 110 AND, 111 OR
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result
- res  out  WIDTH  result, encoded in the format selected by sel
- ovf  out  1  true result not representable in the format
- zero  out  1  res represents zero
- neg  out  1  res is negative (sign bit of delivered res; always 0 when zero=1)

Behaviour:
- Reset: clk and rst are the only clock/reset. Reset is synchronous and active-high. While rst=1 at a clock edge, v1, v2, out_valid, res, ovf, zero and neg are cleared to 0. Any in-flight beats are dropped. In the cycle after reset, in_ready=1.
- Handshake: a beat transfers on in_valid & in_ready, and on out_valid & out_ready.
  - in_ready = ~v1 | ~v2 | out_ready (combinational).
  - While out_valid=1 and out_ready=0, res/ovf/zero/neg hold stable.
  - No beat is lost, duplicated or reordered.
- Latency and throughput: 2 cycles from accept to out_valid. Throughput is 1 beat/cycle when out_ready=1.
- Stage 1 (decode), registered:
  - Sign = operand MSB for all formats.
  - Magnitude (WIDTH bits): 2C = two's negation if negative; 1C = bitwise invert if negative; SM = MSB cleared.
  - Negative zero (1C all-ones, SM 0x80..0) decodes as +0.
  - For sub, the sign of B is inverted (effective add).
  - AND/OR result opA&opB / opA|opB is computed here on raw bits.
- Stage 2 (compute/encode), registered:
  - Same signs: magnitude = magA+magB at WIDTH+1 bits, sign = common sign.
  - Different signs: magnitude = |magA-magB|, sign = sign of the larger operand; equal magnitudes give +0.
- Range and overflow:
  - 2C range: [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - 1C/SM range: ±(2^(WIDTH-1)-1).
  - ovf=1 when the true result is outside the range.
- Overflow handling:
  - SATURATE=1: res = max positive or min negative of the format.
  - SATURATE=0, 2C: res = true result mod 2^WIDTH.
  - SATURATE=0, 1C/SM: sign = true sign; magnitude = true magnitude mod 2^(WIDTH-1). A zero magnitude encodes as +0 and clears neg.
- Encoding: zero results are always all-zeros (never -0).
- Logic ops: ovf=0, zero=(res==0), neg=res[WIDTH-1].
- Stage advance: stage 2 loads when ~v2 | out_ready. Stage 1 loads when in_ready.
- Simultaneous accept and drain in the same cycle is permitted. The pipeline stays full with no bubble.

Test Plan:
- WIDTH=8, SATURATE=0, sel=000, opA=0x7F, opB=0x01 -> res=0x80, ovf=1, neg=1, zero=0, out_valid exactly 2 cycles after accept.
- sel=011, opA=0xFE (-1), opB=0x01 -> res=0xFD, ovf=0, neg=1. Then sel=010, opA=0xFF (-0), opB=0x00 -> res=0x00, zero=1, neg=0.
- sel=100, opA=0x85, opB=0x05 -> res=0x00, zero=1, neg=0. sel=101, opA=0x03, opB=0x05 -> res=0x82, neg=1.
- SATURATE=1:
  - sel=001, opA=0x80, opB=0x01 -> res=0x80, ovf=1.
  - sel=100, opA=0xFF, opB=0x81 -> res=0xFF, ovf=1.
  - sel=110, opA=0xF0, opB=0x3C -> res=0x30.
- Backpressure: stream 6 back-to-back beats, out_ready=0 for cycles 3-6 -> in_ready drops once v1&v2, res held stable, all 6 results delivered in order with no duplicates. With out_ready=1, 1 result/cycle.
- Reset mid-flight: rst=1 for one cycle with 2 beats in flight -> next cycle out_valid=0, res=0, flags=0, in_ready=1. A new beat is accepted and completes normally.
